// File: rtl/entry_input_conditioner_if.sv
// Raw switch/button lines into the entry input conditioner and its conditioned
// select/strobe outputs toward the time-entry stage.
interface entry_input_conditioner_if;
  logic ms_raw;
  logic s_raw;
  logic min_raw;
  logic hr_raw;
  logic btn_raw;
  logic ms_sw;
  logic s_sw;
  logic min_sw;
  logic hr_sw;
  logic add_time;

  modport master (
    output ms_raw, s_raw, min_raw, hr_raw, btn_raw,
    input  ms_sw, s_sw, min_sw, hr_sw, add_time
  );

  modport slave (
    input  ms_raw, s_raw, min_raw, hr_raw, btn_raw,
    output ms_sw, s_sw, min_sw, hr_sw, add_time
  );
endinterface

// File: rtl/entry_input_conditioner.sv
// Synchronizes and debounces the field-select switches and increment button, then
// issues single-cycle add_time strobes. Define ENTRY_AUTO_REPEAT_EN for hold-to-repeat.
module entry_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                      clk,
  input logic                      rst_n,
  entry_input_conditioner_if.slave bus
);
  localparam int NCH   = 5;
  localparam int BTN   = 4;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
`ifdef ENTRY_AUTO_REPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("entry_input_conditioner: timing parameters must be at least 1");
  end

  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   sync1_r;
  logic [NCH-1:0]   sync2_r;
  logic [NCH-1:0]   stable_r;
  logic [NCH-1:0]   toggle_s;
  logic [CNT_W-1:0] cnt_r [NCH];

  logic       ms_sw_r, s_sw_r, min_sw_r, hr_sw_r;
  logic       any_sel_s;
  logic       btn_stable_s, btn_fall_s;
  logic [1:0] state_r, state_s;
  logic       pulse_req_r, pulse_req_s;
  logic       add_time_r, add_time_s;
`ifdef ENTRY_AUTO_REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_s;
`endif

  assign raw_s = {bus.btn_raw, bus.hr_raw, bus.min_raw, bus.s_raw, bus.ms_raw};

  // Two-flop synchronizers on every raw input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= {NCH{1'b0}};
      sync2_r <= {NCH{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // A channel flips when its disagreement count is about to reach DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      toggle_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
    end
  end

  // Per-channel debounce counters and accepted stable values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) begin
        cnt_r[i]    <= {CNT_W{1'b0}};
        stable_r[i] <= 1'b0;
      end else if (toggle_s[i]) begin
        cnt_r[i]    <= {CNT_W{1'b0}};
        stable_r[i] <= ~stable_r[i];
      end else if (sync2_r[i] != stable_r[i]) begin
        cnt_r[i]    <= cnt_r[i] + CNT_ONE;
        stable_r[i] <= stable_r[i];
      end else begin
        cnt_r[i]    <= {CNT_W{1'b0}};
        stable_r[i] <= stable_r[i];
      end
    end
  end

  // Priority-encode the debounced switches (ms > s > min > hr) into registered selects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_sw_r  <= 1'b0;
      s_sw_r   <= 1'b0;
      min_sw_r <= 1'b0;
      hr_sw_r  <= 1'b0;
    end else begin
      ms_sw_r  <= stable_r[0];
      s_sw_r   <= stable_r[1] & ~stable_r[0];
      min_sw_r <= stable_r[2] & ~stable_r[1] & ~stable_r[0];
      hr_sw_r  <= stable_r[3] & ~stable_r[2] & ~stable_r[1] & ~stable_r[0];
    end
  end

  assign any_sel_s    = ms_sw_r | s_sw_r | min_sw_r | hr_sw_r;
  assign btn_stable_s = stable_r[BTN];
  // Suppress a strobe that would coincide with the debounced button releasing.
  assign btn_fall_s   = stable_r[BTN] & toggle_s[BTN];

  // Button FSM next-state, pulse request and strobe qualification.
  always_comb begin
    state_s     = state_r;
    pulse_req_s = 1'b0;
`ifdef ENTRY_AUTO_REPEAT_EN
    rpt_cnt_s   = rpt_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (btn_stable_s) begin
          state_s     = ST_HELD;
          pulse_req_s = 1'b1;
`ifdef ENTRY_AUTO_REPEAT_EN
          rpt_cnt_s   = {RPT_W{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!btn_stable_s) begin
          state_s = ST_IDLE;
`ifdef ENTRY_AUTO_REPEAT_EN
        end else if (rpt_cnt_r == DELAY_LAST) begin
          state_s     = ST_REPEAT;
          pulse_req_s = 1'b1;
          rpt_cnt_s   = {RPT_W{1'b0}};
        end else begin
          rpt_cnt_s = rpt_cnt_r + RPT_ONE;
        end
`else
        end else begin
          state_s = ST_HELD;
        end
`endif
      end
`ifdef ENTRY_AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (!btn_stable_s) begin
          state_s = ST_IDLE;
        end else if (rpt_cnt_r == PERIOD_LAST) begin
          pulse_req_s = 1'b1;
          rpt_cnt_s   = {RPT_W{1'b0}};
        end else begin
          rpt_cnt_s = rpt_cnt_r + RPT_ONE;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    add_time_s = pulse_req_r & any_sel_s & btn_stable_s & ~btn_fall_s & ~add_time_r;
  end

  // FSM state, pending-pulse flag, repeat timer and the registered strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pulse_req_r <= 1'b0;
      add_time_r  <= 1'b0;
`ifdef ENTRY_AUTO_REPEAT_EN
      rpt_cnt_r   <= {RPT_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      pulse_req_r <= pulse_req_s;
      add_time_r  <= add_time_s;
`ifdef ENTRY_AUTO_REPEAT_EN
      rpt_cnt_r   <= rpt_cnt_s;
`endif
    end
  end

  assign bus.ms_sw    = ms_sw_r;
  assign bus.s_sw     = s_sw_r;
  assign bus.min_sw   = min_sw_r;
  assign bus.hr_sw    = hr_sw_r;
  assign bus.add_time = add_time_r;
endmodule

// File: tb/tb_entry_input_conditioner.sv
// Randomized and directed bench for entry_input_conditioner against a sliding-window
// reference model of synchronizer, debounce, select priority and strobe timing.
module tb_entry_input_conditioner;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int MAXC = 4000;
`ifdef ENTRY_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  entry_input_conditioner_if bus ();

  entry_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference history, indexed by edge number: value after that edge.
  int       cyc = 0;
  bit       s2h  [5][MAXC];
  bit       stab [5][MAXC];
  bit [3:0] selh [MAXC];
  bit       addh [MAXC];
  bit [4:0] m_s1 = 5'b00000;
  int       last_rise = -1;

  function automatic logic [3:0] sel_now();
    return {bus.ms_sw, bus.s_sw, bus.min_sw, bus.hr_sw};
  endfunction

  task automatic set_sw(input bit [3:0] v);
    bus.ms_raw  = v[3];
    bus.s_raw   = v[2];
    bus.min_raw = v[1];
    bus.hr_raw  = v[0];
  endtask

  // Advance one clock edge and update the reference model from the inputs sampled there.
  task automatic step();
    bit [4:0] raw;
    bit       rst;
    bit       all_diff;
    int       t;
    int       d;
    @(posedge clk);
    raw = {bus.btn_raw, bus.hr_raw, bus.min_raw, bus.s_raw, bus.ms_raw};
    rst = ~rst_n;
    cyc++;
    t = cyc;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", t, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    for (int ch = 0; ch < 5; ch++) begin
      s2h[ch][t]  = rst ? 1'b0 : m_s1[ch];
      m_s1[ch]    = rst ? 1'b0 : raw[ch];
      stab[ch][t] = rst ? 1'b0 : stab[ch][t-1];
      if (!rst && t > D) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) begin
          if (s2h[ch][t-k] == stab[ch][t-1]) all_diff = 1'b0;
        end
        if (all_diff) stab[ch][t] = ~stab[ch][t-1];
      end
    end
    if (rst)                selh[t] = 4'b0000;
    else if (stab[0][t-1])  selh[t] = 4'b1000;
    else if (stab[1][t-1])  selh[t] = 4'b0100;
    else if (stab[2][t-1])  selh[t] = 4'b0010;
    else if (stab[3][t-1])  selh[t] = 4'b0001;
    else                    selh[t] = 4'b0000;
    addh[t] = 1'b0;
    if (rst) begin
      last_rise = -1;
    end else begin
      if (!stab[4][t])          last_rise = -1;
      else if (!stab[4][t-1])   last_rise = t;
      if (last_rise >= 0 && selh[t-1] != 4'b0000) begin
        d = t - last_rise;
        if (d == 2) addh[t] = 1'b1;
        else if (REPEAT_ON && d >= 2 + RD && ((d - 2 - RD) % RP) == 0) addh[t] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_sw(4'b1111);
    bus.btn_raw = 1'b1;
    repeat (3) begin
      step();
      total++;
      if (sel_now() !== 4'b0000 || bus.add_time !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got sel=%b add=%b want sel=0000 add=0", cyc, sel_now(), bus.add_time);
      end
    end
    set_sw(4'b0000);
    bus.btn_raw = 1'b0;
    rst_n = 1'b1;
    repeat (10) begin
      step();
      total++;
      if (sel_now() !== selh[cyc] || bus.add_time !== addh[cyc]) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got sel=%b add=%b want sel=%b add=%b", cyc, sel_now(), bus.add_time, selh[cyc], addh[cyc]);
      end
    end
  endtask

  task automatic test_single_press();
    int t0;
    int pulses = 0;
    int first = -1;
    set_sw(4'b1000);
    repeat (12) step();
    total++;
    if (sel_now() !== 4'b1000) begin
      bad++;
      $display("FAIL single_sel got=%b want=1000", sel_now());
    end
    bus.btn_raw = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      if (cyc == t0 + 9) bus.btn_raw = 1'b0;
      step();
      total++;
      if (bus.add_time !== addh[cyc]) begin
        bad++;
        $display("FAIL single_add cyc=%0d got=%b want=%b", cyc, bus.add_time, addh[cyc]);
      end
      if (bus.add_time === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    total++;
    if (pulses != 1 || first - t0 != D + 3) begin
      bad++;
      $display("FAIL single_latency got pulses=%0d offset=%0d want pulses=1 offset=%0d", pulses, first - t0, D + 3);
    end
  endtask

  task automatic test_bounce();
    set_sw(4'b1000);
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) bus.btn_raw = ~bus.btn_raw;
      step();
      total++;
      if (bus.add_time !== 1'b0 || addh[cyc] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_add cyc=%0d got=%b model=%b want=0", cyc, bus.add_time, addh[cyc]);
      end
    end
    bus.btn_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_priority();
    set_sw(4'b0110);
    repeat (12) step();
    total++;
    if (sel_now() !== 4'b0100 || sel_now() !== selh[cyc]) begin
      bad++;
      $display("FAIL priority_sel got=%b want=0100 model=%b", sel_now(), selh[cyc]);
    end
    set_sw(4'b0000);
    repeat (12) step();
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) bus.btn_raw = 1'b0;
      step();
      total++;
      if (bus.add_time !== 1'b0 || sel_now() !== selh[cyc]) begin
        bad++;
        $display("FAIL nosel_add cyc=%0d got add=%b sel=%b want add=0 sel=%b", cyc, bus.add_time, sel_now(), selh[cyc]);
      end
    end
  endtask

  task automatic test_repeat();
    int p0 = -1;
    int offs[$];
    int exp_off[$];
    if (REPEAT_ON) exp_off = '{0, 10, 15, 20, 25, 30};
    else           exp_off = '{0};
    set_sw(4'b0001);
    repeat (12) step();
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 20 && p0 < 0; i++) begin
      step();
      if (bus.add_time === 1'b1) p0 = cyc;
    end
    total++;
    if (p0 < 0) begin
      bad++;
      $display("FAIL repeat_first got=none want=pulse within 20 cycles");
    end else begin
      offs.push_back(0);
      while (cyc < p0 + 45) begin
        if (cyc == p0 + 29) bus.btn_raw = 1'b0;
        step();
        total++;
        if (bus.add_time !== addh[cyc]) begin
          bad++;
          $display("FAIL repeat_add cyc=%0d got=%b want=%b", cyc, bus.add_time, addh[cyc]);
        end
        if (bus.add_time === 1'b1) offs.push_back(cyc - p0);
      end
      total++;
      if (offs.size() != exp_off.size()) begin
        bad++;
        $display("FAIL repeat_count got=%0d want=%0d", offs.size(), exp_off.size());
      end
      for (int i = 0; i < offs.size() && i < exp_off.size(); i++) begin
        total++;
        if (offs[i] != exp_off[i]) begin
          bad++;
          $display("FAIL repeat_offset idx=%0d got=%0d want=%0d", i, offs[i], exp_off[i]);
        end
      end
    end
    bus.btn_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset_mid_repeat();
    int rel;
    int found = -1;
    set_sw(4'b0001);
    repeat (12) step();
    bus.btn_raw = 1'b1;
    repeat (D + 20) begin
      step();
      total++;
      if (bus.add_time !== addh[cyc]) begin
        bad++;
        $display("FAIL midrst_pre cyc=%0d got=%b want=%b", cyc, bus.add_time, addh[cyc]);
      end
    end
    rst_n = 1'b0;
    step();
    total++;
    if (sel_now() !== 4'b0000 || bus.add_time !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear got sel=%b add=%b want sel=0000 add=0", sel_now(), bus.add_time);
    end
    rst_n = 1'b1;
    rel = cyc + 1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      step();
      total++;
      if (bus.add_time !== addh[cyc]) begin
        bad++;
        $display("FAIL midrst_add cyc=%0d got=%b want=%b", cyc, bus.add_time, addh[cyc]);
      end
      if (bus.add_time === 1'b1) found = cyc;
    end
    total++;
    if (found < 0 || found - rel != D + 3) begin
      bad++;
      $display("FAIL midrst_latency got=%0d want=%0d", (found < 0) ? -1 : found - rel, D + 3);
    end
    bus.btn_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_random();
    bit [3:0] sw = 4'b0000;
    bit       prev_add = 1'b0;
    set_sw(sw);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        sw[$urandom_range(0, 3)] ^= 1'b1;
        set_sw(sw);
      end
      if ($urandom_range(0, 11) == 0) bus.btn_raw = ~bus.btn_raw;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
      total++;
      if (sel_now() !== selh[cyc] || bus.add_time !== addh[cyc]) begin
        bad++;
        $display("FAIL random cyc=%0d got sel=%b add=%b want sel=%b add=%b", cyc, sel_now(), bus.add_time, selh[cyc], addh[cyc]);
      end
      total++;
      if ((prev_add & bus.add_time) !== 1'b0) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=1 want=0", cyc);
      end
      prev_add = bus.add_time;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    set_sw(4'b0000);
    bus.btn_raw = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_priority();
    test_repeat();
    test_reset_mid_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/entry_input_conditioner.md
ENTRY_INPUT_CONDITIONER -- requirements
Module: entry_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a raw-input change (minimum 1).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, cycles from the first add_time pulse to the first auto-repeat pulse (minimum 1).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between consecutive auto-repeat pulses (minimum 1).
REQ-004 The block SHALL have the port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have the port ms_raw, s_raw, min_raw, hr_raw, input, 1 each, asynchronous field-select switches.
REQ-007 The block SHALL have the port btn_raw, input, 1, the asynchronous, bouncing increment button.
REQ-008 The block SHALL have the port ms_sw, s_sw, min_sw, hr_sw, output, 1 each, conditioned one-hot field select driving the time-entry stage.
REQ-009 The block SHALL have the port add_time, output, 1, a single-cycle increment strobe driving the time-entry stage.

Function
REQ-010 Each of the five raw inputs SHALL pass through its own two-flop synchronizer before any other logic.
REQ-011 Each synchronized input SHALL have an independent debouncer: a counter of width clog2(DEBOUNCE_CYCLES+1) that increments while the synchronized value differs from the stable value and clears on any agreeing cycle.
REQ-012 A stable value SHALL toggle on the edge where its counter reaches DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-013 Select outputs SHALL be registered, one-hot or all-zero, priority ms > s > min > hr over the stable switch values.
REQ-014 The button FSM SHALL have states IDLE, HELD and REPEAT.
REQ-015 IDLE -> HELD on the stable-button rising edge; add_time SHALL assert for exactly one cycle on the following edge, registered.
REQ-016 Total latency from the first edge sampling btn_raw high (held clean) to add_time high SHALL be DEBOUNCE_CYCLES+3 cycles.
REQ-017 HELD and REPEAT SHALL return to IDLE the cycle the stable button falls, with no pulse issued at or after release.
REQ-018 A pulse SHALL be qualified by the select outputs registered in the same cycle; if all select outputs are zero, add_time stays low while the FSM still advances.
REQ-019 add_time SHALL never be high on two consecutive cycles.
REQ-020 Select changes while the button is held SHALL take effect for the next pulse only, with no extra pulse generated.

Reset
REQ-021 While rst_n is low at a clock edge, synchronizers, stable values, counters and all outputs SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abort the operation; a button still physically held on release of reset SHALL be treated as a fresh press after debounce.

Configuration
REQ-023 With macro ENTRY_AUTO_REPEAT_EN defined, HELD SHALL move to REPEAT and issue a pulse REPEAT_DELAY cycles after the initial pulse, then a pulse every REPEAT_PERIOD cycles while held, using a repeat counter of width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
REQ-024 Without ENTRY_AUTO_REPEAT_EN, the REPEAT state and repeat counter SHALL be absent, and exactly one pulse SHALL issue per press regardless of hold duration.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-025 ms_raw=1, then clean btn_raw press held 3 cycles past debounce -> ms_sw=1 only; one add_time pulse exactly 7 cycles after the first high sample.
REQ-026 btn_raw toggling every 2 cycles for 40 cycles -> add_time stays 0 throughout.
REQ-027 s_raw=1, min_raw=1 -> s_sw=1, min_sw=0; all switches 0 plus a button press -> add_time stays 0.
REQ-028 With ENTRY_AUTO_REPEAT_EN, button held 30 cycles past the first pulse -> pulses at offsets 0, 10, 15, 20, 25, 30; without the macro, only offset 0.
REQ-029 rst_n low for 1 cycle during REPEAT with the button held -> outputs 0 next edge; a new pulse 7 cycles after reset release.
